rx_frame_controller: RTL and testbench

RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

---
 rtl/rx_frame_controller.sv | 200 ++++++++++++++++++++
 tb/tb_rx_frame_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_controller.sv
// Oversampled UART receive framer: samples start/data/parity/stop mid-bit on baud ticks,
// hands the raw frame to an external error checker and buffers one checked byte for a consumer.
module rx_frame_controller #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       data_rx,
  input  logic [1:0] parity_type,
  input  logic [2:0] error_flag,
  output logic       recieved_flag,
  output logic [7:0] raw_data,
  output logic       parity_bit,
  output logic       start_bit,
  output logic       stop_bit,
  output logic [7:0] data_out,
  output logic [2:0] err_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       overrun,
  input  logic       clear_overrun
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntMid  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      ptype_q, ptype_d;
  logic [7:0]      raw_q, raw_d;
  logic            par_q, par_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic [7:0]      dout_q, dout_d;
  logic [2:0]      err_q, err_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;

  logic tick_mid, tick_last, done, ovr_set, par_en;

  assign tick_mid  = baud_tick && (cnt_q == CntMid);
  assign tick_last = baud_tick && (cnt_q == CntLast);
  assign done      = (state_q == StDone);
  assign par_en    = (ptype_q == 2'b01) || (ptype_q == 2'b10);
  assign ovr_set   = done && valid_q && !out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ptype_d = ptype_q;
    raw_d   = raw_q;
    par_d   = par_q;
    start_d = start_q;
    stop_d  = stop_q;

    // Counter runs through every bit period; the IDLE and DONE arms override it.
    if (baud_tick) begin
      cnt_d = tick_last ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (baud_tick && !data_rx) begin
          state_d = StStart;
          ptype_d = parity_type;
        end
      end
      StStart: begin
        if (tick_mid) begin
          if (data_rx) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            start_d = 1'b0;
          end
        end else if (tick_last) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick_mid) begin
          raw_d[idx_q] = data_rx;
        end
        if (tick_last) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (par_en) begin
              state_d = StParity;
            end else begin
              state_d = StStop;
              par_d   = 1'b0;
            end
          end
        end
      end
      StParity: begin
        if (tick_mid) begin
          par_d = data_rx;
        end
        if (tick_last) begin
          state_d = StStop;
        end
      end
      StStop: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (tick_mid) begin
          stop_d  = data_rx;
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    err_d   = err_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (done && (!valid_q || out_ready)) begin
      dout_d  = raw_q;
      err_d   = error_flag;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clear_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      ptype_q <= '0;
      raw_q   <= '0;
      par_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b1;
      dout_q  <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ptype_q <= ptype_d;
      raw_q   <= raw_d;
      par_q   <= par_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign recieved_flag = done;
  assign busy          = (state_q != StIdle);
  assign raw_data      = raw_q;
  assign parity_bit    = par_q;
  assign start_bit     = start_q;
  assign stop_bit      = stop_q;
  assign data_out      = dout_q;
  assign err_out       = err_q;
  assign out_valid     = valid_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench for rx_frame_controller: a vector table of whole frames plus hand-written
// sequences for false start, ready-in-DONE, overrun and mid-frame reset.
module tb_rx_frame_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_tick = 1'b0;
  logic       data_rx;
  logic [1:0] parity_type;
  logic [2:0] error_flag;
  logic       recieved_flag;
  logic [7:0] raw_data;
  logic       parity_bit, start_bit, stop_bit;
  logic [7:0] data_out;
  logic [2:0] err_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;
  logic       clear_overrun;

  int tests = 0;
  int fails = 0;
  int rf_cnt = 0;

  rx_frame_controller #(.OVERSAMPLE(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .baud_tick     (baud_tick),
    .data_rx       (data_rx),
    .parity_type   (parity_type),
    .error_flag    (error_flag),
    .recieved_flag (recieved_flag),
    .raw_data      (raw_data),
    .parity_bit    (parity_bit),
    .start_bit     (start_bit),
    .stop_bit      (stop_bit),
    .data_out      (data_out),
    .err_out       (err_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clock = ~clock;

  // Baud tick every third clock, changed on the falling edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clock);
      baud_tick = (div == 0);
      div = (div == 2) ? 0 : div + 1;
    end
  end

  // Stand-in for the downstream error checker.
  always_comb begin
    error_flag[0] = ((parity_type == 2'b01) || (parity_type == 2'b10)) &&
                    ((^{raw_data, parity_bit}) != (parity_type == 2'b01));
    error_flag[1] = (start_bit != 1'b0);
    error_flag[2] = (stop_bit != 1'b1);
  end

  always @(negedge clock) begin
    if (recieved_flag === 1'b1) rf_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; holds the line for n baud ticks and returns at a falling edge.
  task automatic hold_bit(input logic b, input int n);
    data_rx = b;
    for (int k = 0; k < n; ) begin
      @(posedge clock);
      if (baud_tick) k++;
      @(negedge clock);
    end
  endtask

  task automatic send_head(input logic [7:0] d, input logic [1:0] pt, input logic pb);
    parity_type = pt;
    hold_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_bit(d[i], 16);
    if (pt == 2'b01 || pt == 2'b10) hold_bit(pb, 16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                            input logic st);
    send_head(d, pt, pb);
    hold_bit(st, 16);
    hold_bit(1'b1, 20);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " raw_data"},   raw_data, 0);
    chk({tag, " parity_bit"}, parity_bit, 0);
    chk({tag, " start_bit"},  start_bit, 0);
    chk({tag, " stop_bit"},   stop_bit, 1);
    chk({tag, " data_out"},   data_out, 0);
    chk({tag, " err_out"},    err_out, 0);
    chk({tag, " out_valid"},  out_valid, 0);
    chk({tag, " rx_flag"},    recieved_flag, 0);
    chk({tag, " busy"},       busy, 0);
    chk({tag, " overrun"},    overrun, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] ptype;
    logic       pbit;
    logic       stop;
    logic       drain;
    logic       clr;
    logic [7:0] exp_dout;
    logic [2:0] exp_err;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int rf0;
    vecs[0] = '{8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 3'b000, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 3'b001, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 3'b100, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 3'b100, 1'b1, 1'b1};
    vecs[4] = '{8'h96, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h96, 3'b000, 1'b1, 1'b1};
    vecs[5] = '{8'h0F, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 3'b001, 1'b1, 1'b1};
    vecs[6] = '{8'hC3, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 3'b000, 1'b1, 1'b1};
    vecs[7] = '{8'h42, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h42, 3'b000, 1'b1, 1'b0};

    reset_n       = 1'b0;
    data_rx       = 1'b1;
    parity_type   = 2'b00;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("reset");
    reset_n = 1'b1;
    hold_bit(1'b1, 4);

    // False start: line low for 4 ticks only.
    rf0 = rf_cnt;
    hold_bit(1'b0, 4);
    chk("false_start busy", busy, 1);
    hold_bit(1'b1, 20);
    chk("false_start idle", busy, 0);
    chk("false_start rx_flag", rf_cnt - rf0, 0);
    chk("false_start valid", out_valid, 0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].clr) begin
        clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0;
      end
      if (vecs[v].drain) begin
        pulse_ready();
        chk($sformatf("v%0d drained", v), out_valid, 0);
      end
      rf0 = rf_cnt;
      send_frame(vecs[v].data, vecs[v].ptype, vecs[v].pbit, vecs[v].stop);
      chk($sformatf("v%0d rx_flag", v), rf_cnt - rf0, 1);
      chk($sformatf("v%0d raw_data", v), raw_data, vecs[v].data);
      chk($sformatf("v%0d data_out", v), data_out, vecs[v].exp_dout);
      chk($sformatf("v%0d err_out", v), err_out, vecs[v].exp_err);
      chk($sformatf("v%0d out_valid", v), out_valid, vecs[v].exp_valid);
      chk($sformatf("v%0d overrun", v), overrun, vecs[v].exp_ovr);
      chk($sformatf("v%0d busy", v), busy, 0);
    end

    // Consumer ready exactly in the DONE cycle while a frame is still held.
    send_head(8'hE7, 2'b00, 1'b0);
    data_rx = 1'b1;
    for (int k = 0; k < 200 && recieved_flag !== 1'b1; k++) @(negedge clock);
    chk("done_ready rx_flag seen", recieved_flag, 1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    hold_bit(1'b1, 20);
    chk("done_ready data_out", data_out, 8'hE7);
    chk("done_ready out_valid", out_valid, 1);
    chk("done_ready overrun", overrun, 0);

    // Dropped frame sets overrun before the reset test.
    send_frame(8'h11, 2'b00, 1'b0, 1'b1);
    chk("drop data_out", data_out, 8'hE7);
    chk("drop overrun", overrun, 1);

    // Reset in the middle of data bit 4.
    parity_type = 2'b00;
    hold_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) hold_bit(1'b0, 16);
    hold_bit(1'b0, 5);
    chk("abort busy", busy, 1);
    rf0 = rf_cnt;
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset("midreset");
    reset_n = 1'b1;
    hold_bit(1'b1, 20);
    chk("abort rx_flag", rf_cnt - rf0, 0);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1);
    chk("after_reset rx_flag", rf_cnt - rf0, 1);
    chk("after_reset data_out", data_out, 8'hFF);
    chk("after_reset err_out", err_out, 0);
    chk("after_reset out_valid", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
